hit_count_accum: RTL and testbench
==================================

// Module: hit_count_accum
// PURPOSE
//   Downstream of the 16-bit bitsum stage. Accumulates the per-word hit counts
//   (0..16 each) over one APV frame of WORDS_PER_FRAME words into a frame
//   occupancy total. Compares the total against a programmable limit so the
//   zero-suppression controller can flag or drop overloaded frames.
//   Reports frames that end early (truncated) through an error flag.
// PARAMETERS
//   WORDS_PER_FRAME  8  number of in_count words per frame (8 x 16 = 128 channels)
//   CNT_W            8  accumulator / out_count width; saturates at 2^CNT_W-1
// PORTS
//   clk          in   1      system clock, all logic on rising edge
//   rstn         in   1      asynchronous active-low reset
//   frame_start  in   1      1-cycle pulse: a new frame begins
//   in_valid     in   1      in_count is valid this cycle
//   in_count     in   7      hit count of one 16-bit word (legal range 0..16)
//   occ_limit    in   CNT_W  occupancy limit, sampled at frame_start
//   out_valid    out  1      1-cycle pulse: frame result valid
//   out_count    out  CNT_W  frame hit total; held until the next out_valid
//   out_over     out  1      out_count > occ_limit sampled for this frame; qualified by out_valid
//   out_err      out  1      frame truncated by frame_start; qualified by out_valid
//   busy         out  1      high while in ACCUM
// BEHAVIOUR
//   Reset (rstn=0, async): state=IDLE; acc, word_cnt, limit_q, out_count all 0;
//     out_valid, out_over, out_err, busy all 0.
//   States: IDLE, ACCUM.
//   IDLE:
//     - in_valid is ignored.
//     - frame_start: acc<=0, word_cnt<=0, limit_q<=occ_limit, go to ACCUM.
//     - If in_valid is high in the same cycle as frame_start, that word is the
//       frame's first word: acc<=in_count, word_cnt<=1.
//   ACCUM, on each in_valid:
//     - acc <= sat(acc + in_count): clamp at 2^CNT_W-1, never wraps.
//     - word_cnt <= word_cnt + 1.
//     - in_count > 16 is not checked and is added as-is.
//   Frame end: the in_valid that brings word_cnt to WORDS_PER_FRAME.
//     Next cycle (latency 1):
//       out_valid=1; out_count=final acc; out_over=(final acc > limit_q); out_err=0.
//     State returns to IDLE.
//   Frame end and frame_start in the same cycle:
//     - the result of the finished frame is issued normally;
//     - the new frame starts directly in ACCUM (no idle cycle).
//   frame_start in ACCUM before the frame completes (truncation):
//     - Next cycle: out_valid=1, out_err=1, out_count=partial acc including any
//       in_valid word of the previous cycle, out_over computed as normal.
//     - The new frame starts as for frame_start in IDLE, including the
//       same-cycle in_valid rule; state stays ACCUM.
//   out_valid is high for exactly one cycle per frame result.
//     out_count, out_over and out_err hold their values until the next out_valid.
//   busy = (state == ACCUM).
//   occ_limit changes mid-frame have no effect; limit_q is used.
//   Reset asserted mid-frame: the partial frame is discarded; no out_valid is issued.
// TESTING
//   1. frame_start; 8 words of 2 with in_valid=1, occ_limit=20
//        -> out_valid 1 cycle after word 8; out_count=16, out_over=0, out_err=0.
//   2. 8 words of 16, occ_limit=100
//        -> out_count=128, out_over=1.
//      Same frame with CNT_W=6 -> out_count=63 (saturated).
//   3. frame_start, 3 words of 5, then frame_start with in_valid=1, in_count=4
//        -> out_valid with out_count=15, out_err=1.
//      The new frame starts with acc=4; after 7 more words of 0 -> out_count=4.
//   4. in_valid with gaps (valid on alternate cycles), 8 words of 1
//        -> out_count=8, single out_valid pulse.
//      in_valid pulses in IDLE before frame_start -> no effect on the result.
//   5. Word 8 and the next frame_start in the same cycle
//        -> previous frame reported with out_err=0; next frame counted without loss.
//   6. rstn=0 after 4 words
//        -> all outputs 0 immediately; no out_valid after release until a new
//           frame completes.

Source files
------------

// File: rtl/hit_count_accum.sv
// Per-frame hit accumulator: sums WORDS_PER_FRAME word hit counts with saturation,
// reports the total, an over-limit flag and a truncation flag one cycle after frame end.
module hit_count_accum #(
   parameter int unsigned WORDS_PER_FRAME = 8,
   parameter int unsigned CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             frame_start,
   input  logic             in_valid,
   input  logic [6:0]       in_count,
   input  logic [CNT_W-1:0] occ_limit,
   output logic             out_valid,
   output logic [CNT_W-1:0] out_count,
   output logic             out_over,
   output logic             out_err,
   output logic             busy
);

   localparam int unsigned WC_W  = $clog2(WORDS_PER_FRAME + 1);
   localparam int unsigned SUM_W = ((CNT_W > 7) ? CNT_W : 7) + 1;
   localparam logic [SUM_W-1:0] SAT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};
   localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(WORDS_PER_FRAME - 1);

   typedef enum logic [0:0] {StIdle, StAccum} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   logic [WC_W-1:0]  wc_q, wc_d;
   logic [CNT_W-1:0] limit_q, limit_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic             out_over_q, out_over_d;
   logic             out_err_q, out_err_d;
   logic             out_valid_q, out_valid_d;
   logic [CNT_W-1:0] acc_sum, first_sum;
   logic             last_word;

   // Wide enough that in_count up to 127 cannot wrap before the clamp.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [6:0] b);
      logic [SUM_W-1:0] s;
      s = SUM_W'(a) + SUM_W'(b);
      if (s > SAT_MAX) s = SAT_MAX;
      return s[CNT_W-1:0];
   endfunction

   assign acc_sum   = sat_add(acc_q, in_count);
   assign first_sum = sat_add('0, in_count);
   assign last_word = in_valid && (wc_q == LAST_WORD);

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      wc_d        = wc_q;
      limit_d     = limit_q;
      out_count_d = out_count_q;
      out_over_d  = out_over_q;
      out_err_d   = out_err_q;
      out_valid_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (frame_start) begin
               state_d = StAccum;
               acc_d   = in_valid ? first_sum : '0;
               wc_d    = in_valid ? WC_W'(1) : '0;
               limit_d = occ_limit;
            end
         end
         StAccum: begin
            if (last_word) begin
               out_valid_d = 1'b1;
               out_count_d = acc_sum;
               out_over_d  = acc_sum > limit_q;
               out_err_d   = 1'b0;
               // The word completing this frame is consumed; a coincident start begins empty.
               if (frame_start) begin
                  acc_d   = '0;
                  wc_d    = '0;
                  limit_d = occ_limit;
               end else begin
                  state_d = StIdle;
               end
            end else if (frame_start) begin
               out_valid_d = 1'b1;
               out_count_d = acc_q;
               out_over_d  = acc_q > limit_q;
               out_err_d   = 1'b1;
               acc_d       = in_valid ? first_sum : '0;
               wc_d        = in_valid ? WC_W'(1) : '0;
               limit_d     = occ_limit;
            end else if (in_valid) begin
               acc_d = acc_sum;
               wc_d  = wc_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         wc_q        <= '0;
         limit_q     <= '0;
         out_count_q <= '0;
         out_over_q  <= 1'b0;
         out_err_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         wc_q        <= wc_d;
         limit_q     <= limit_d;
         out_count_q <= out_count_d;
         out_over_q  <= out_over_d;
         out_err_q   <= out_err_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_count = out_count_q;
   assign out_over  = out_over_q;
   assign out_err   = out_err_q;
   assign busy      = (state_q == StAccum);

endmodule

// File: tb/tb_hit_count_accum.sv
// Scoreboard bench for hit_count_accum: a frame-level model queues expected results,
// a negedge monitor pops and compares on every out_valid.
module tb_hit_count_accum;

   localparam int WPF   = 8;
   localparam int CNT_W = 8;
   localparam int MAXV  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rstn;
   logic             frame_start, in_valid;
   logic [6:0]       in_count;
   logic [CNT_W-1:0] occ_limit;
   logic             out_valid, out_over, out_err, busy;
   logic [CNT_W-1:0] out_count;

   hit_count_accum #(.WORDS_PER_FRAME(WPF), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn), .frame_start(frame_start), .in_valid(in_valid),
      .in_count(in_count), .occ_limit(occ_limit), .out_valid(out_valid),
      .out_count(out_count), .out_over(out_over), .out_err(out_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {int count; int over; int err;} result_t;
   result_t sb[$];

   int errors = 0;
   int checks = 0;

   // Frame-level reference: words seen so far, their plain sum, and the captured limit.
   bit m_in_frame;
   int m_n, m_total, m_limit;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int total, input int err);
      result_t r;
      r.count = (total > MAXV) ? MAXV : total;
      r.over  = (r.count > m_limit) ? 1 : 0;
      r.err   = err;
      sb.push_back(r);
   endtask

   task automatic start_frame(input bit iv, input int cnt, input int lim);
      m_in_frame = 1;
      m_n        = iv ? 1 : 0;
      m_total    = iv ? cnt : 0;
      m_limit    = lim;
   endtask

   task automatic model(input bit fs, input bit iv, input int cnt, input int lim);
      if (!m_in_frame) begin
         if (fs) start_frame(iv, cnt, lim);
      end else if (iv && m_n == WPF - 1) begin
         push(m_total + cnt, 0);
         m_in_frame = 0;
         if (fs) start_frame(1'b0, 0, lim);
      end else if (fs) begin
         push(m_total, 1);
         start_frame(iv, cnt, lim);
      end else if (iv) begin
         m_total += cnt;
         m_n++;
      end
   endtask

   task automatic step(input bit fs, input bit iv, input int cnt, input int lim);
      frame_start = fs;
      in_valid    = iv;
      in_count    = 7'(cnt);
      occ_limit   = CNT_W'(lim);
      model(fs, iv, cnt, lim);
      @(posedge clk);
      #1;
      check("busy", int'(busy), int'(m_in_frame));
   endtask

   task automatic frame(input int n, input int cnt, input int lim);
      step(1'b1, 1'b0, 0, lim);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, cnt, lim);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_out_valid"}, int'(out_valid), 0);
      check({tag, "_out_count"}, int'(out_count), 0);
      check({tag, "_out_over"}, int'(out_over), 0);
      check({tag, "_out_err"}, int'(out_err), 0);
      check({tag, "_busy"}, int'(busy), 0);
   endtask

   always @(negedge clk) begin
      if (rstn && out_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
         end else begin
            result_t r;
            r = sb.pop_front();
            check("out_count", int'(out_count), r.count);
            check("out_over", int'(out_over), r.over);
            check("out_err", int'(out_err), r.err);
         end
      end
   end

   initial begin
      rstn = 1'b0; frame_start = 1'b0; in_valid = 1'b0; in_count = '0; occ_limit = '0;
      m_in_frame = 0; m_n = 0; m_total = 0; m_limit = 0;
      #1;
      check_zero("reset");
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // Basic frame, large-count frame over limit, saturating frame.
      frame(8, 2, 20);
      step(1'b0, 1'b0, 0, 20);
      step(1'b0, 1'b0, 0, 20);
      check("held_out_count", int'(out_count), 16);
      frame(8, 16, 100);
      step(1'b0, 1'b0, 0, 100);
      frame(8, 100, 50);
      step(1'b0, 1'b0, 0, 50);

      // Truncation with same-cycle first word of the new frame.
      frame(3, 5, 200);
      step(1'b1, 1'b1, 4, 3);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 0, 3);
      step(1'b0, 1'b0, 0, 0);

      // Valid pulses while idle are ignored; gapped valids inside a frame.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 9, 0);
      step(1'b1, 1'b0, 0, 7);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 1, 7);
         step(1'b0, 1'b0, 0, 7);
      end

      // Last word coincides with the next frame_start.
      frame(7, 3, 30);
      step(1'b1, 1'b1, 3, 10);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 2, 10);
      step(1'b0, 1'b0, 0, 0);

      // Reset mid-frame discards the partial frame.
      frame(4, 6, 10);
      rstn = 1'b0;
      #1;
      check_zero("midreset");
      m_in_frame = 0;
      sb.delete();
      @(posedge clk);
      #1;
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 5, 0);

      // Randomised traffic, including occasional out-of-range counts and limit changes.
      for (int i = 0; i < 3000; i++) begin
         bit fs, iv;
         int cnt;
         fs  = ($urandom_range(0, 99) < (m_in_frame ? 4 : 30));
         iv  = ($urandom_range(0, 99) < 70);
         cnt = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 127))
                                            : int'($urandom_range(0, 16));
         step(fs, iv, cnt, int'($urandom_range(0, 140)));
      end

      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0);
      check("pending_results", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
